// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Definitions shared by the instruction-memory loader files:
//   - state_t / ST_* : loader FSM state encoding
//   - HDR_BYTES      : number of header bytes that lead a load stream
//   - calc_depth()   : instruction-memory depth in words for a given address width
package imem_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CHK  = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

    localparam int unsigned HDR_BYTES = 1;

    function automatic int unsigned calc_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Bundles the loader's byte-stream handshake, instruction-memory write port
// and status lines.
//   start, byte_valid, byte_data        : host -> loader
//   byte_ready                          : loader -> host
//   imem_we, imem_addr, imem_wdata      : loader -> instruction memory
//   cpu_reset, busy, done, error        : loader -> core / status
// Modports: slave = loader side, master = host side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output cpu_reset, busy, done, error
    );

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_reset, busy, done, error
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// imem_loader_word_assembler
// Packs bytes into 32-bit little-endian words: the first byte of a word lands
// in bits 7:0, the fourth in bits 31:24.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : restart at byte 0 of a new word
//   shift_en    : byte_in is consumed this cycle
//   byte_in     : stream byte
//   last_byte   : next consumed byte completes a word
//   word_valid  : one-cycle pulse the cycle after a word completes
//   word        : assembled word (valid while word_valid is high)
module imem_loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    always_comb begin
        cnt_d        = cnt_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            cnt_d = 2'd0;
        end else if (shift_en) begin
            // Shifting in from the top leaves the first byte in bits 7:0
            // once four bytes have arrived.
            word_d       = {byte_in, word_q[31:8]};
            cnt_d        = cnt_q + 2'd1;
            word_valid_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= 2'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign last_byte  = (cnt_q == 2'd3);
    assign word_valid = word_valid_q;
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Loads the instruction memory from a byte stream (header N, 4N data bytes,
// XOR checksum) and holds the core in reset until a load completes cleanly.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : imem_loader_if.slave (byte handshake, imem write port,
//                cpu_reset/busy/done/error status)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// HDR   | waiting for the word-count header byte
// DATA  | receiving data bytes, words written one cycle after completion
// CHK   | waiting for the checksum byte
// DONE  | load good, core released from reset
// ERR   | bad length or checksum, core held in reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    imem_loader_if.slave   bus
);

    localparam int unsigned    DEPTH    = calc_depth(ADDR_W);
    localparam logic [ADDR_W:0] WCNT_ONE = 1;

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [7:0]        xor_q, xor_d;
    logic              byte_ready_q, byte_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;

    logic              accept;
    logic              hdr_acc;
    logic              data_acc;
    logic              last_word;
    logic              last_byte;
    logic              word_valid;
    logic [31:0]       word;

    assign accept   = bus.byte_valid & byte_ready_q;
    assign hdr_acc  = accept && (state_q == ST_HDR);
    assign data_acc = accept && (state_q == ST_DATA);
    // Word counter is one bit wider than the address so a full-memory load
    // (N == DEPTH) compares correctly without wrapping.
    assign last_word = (32'(wcnt_q) + 32'd1) == 32'(n_q);

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (hdr_acc),
        .shift_en   (data_acc),
        .byte_in    (bus.byte_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (accept) begin
                    if (32'(bus.byte_data) > DEPTH)  state_d = ST_ERR;
                    else if (bus.byte_data == 8'd0)  state_d = ST_CHK;
                    else                             state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept && last_byte && last_word) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (accept) state_d = (bus.byte_data == xor_q) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        n_d    = hdr_acc ? bus.byte_data : n_q;

        xor_d  = xor_q;
        if (hdr_acc)       xor_d = 8'd0;
        else if (data_acc) xor_d = xor_q ^ bus.byte_data;

        wcnt_d = wcnt_q;
        if (hdr_acc)         wcnt_d = '0;
        else if (word_valid) wcnt_d = wcnt_q + WCNT_ONE;

        busy_d       = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CHK);
        byte_ready_d = busy_d;
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERR);
        // Release the core only once DONE has been held for a full cycle;
        // leaving DONE reasserts reset on the same edge as the state change.
        cpu_reset_d  = !((state_q == ST_DONE) && (state_d == ST_DONE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            n_q          <= 8'd0;
            wcnt_q       <= '0;
            xor_q        <= 8'd0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            wcnt_q       <= wcnt_d;
            xor_q        <= xor_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = wcnt_q[ADDR_W-1:0];
    assign bus.imem_wdata = word;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Drives byte-stream loads into imem_loader and checks every cycle against a
// stream-level model: which word must be written in which cycle, and the
// busy/done/error/cpu_reset status implied by the bytes handed over so far.
module tb_imem_loader;

    localparam int AW = 6;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;

    // stream-level model of the expected outputs
    logic        m_busy, m_done, m_err, m_cpu_rst;
    logic        m_we_due;
    logic [5:0]  m_wr_addr;
    logic [31:0] m_wr_data;

    // observed write history
    int          wr_seen = 0;
    logic [5:0]  last_wr_addr;
    logic [31:0] last_wr_data;

    imem_loader_if #(.ADDR_W(AW)) bus_if ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_cpu_rst = 1'b1;
        m_we_due  = 1'b0;
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        check("imem_we", {31'd0, bus_if.imem_we}, {31'd0, m_we_due});
        if (m_we_due) begin
            check("imem_addr", {26'd0, bus_if.imem_addr}, {26'd0, m_wr_addr});
            check("imem_wdata", bus_if.imem_wdata, m_wr_data);
            m_we_due = 1'b0;
        end
        if (bus_if.imem_we === 1'b1) begin
            wr_seen++;
            last_wr_addr = bus_if.imem_addr;
            last_wr_data = bus_if.imem_wdata;
        end
        check("byte_ready", {31'd0, bus_if.byte_ready}, {31'd0, m_busy});
        check("busy",       {31'd0, bus_if.busy},       {31'd0, m_busy});
        check("done",       {31'd0, bus_if.done},       {31'd0, m_done});
        check("error",      {31'd0, bus_if.error},      {31'd0, m_err});
        check("cpu_reset",  {31'd0, bus_if.cpu_reset},  {31'd0, m_cpu_rst});
    end

    task automatic do_start();
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        m_busy    = 1'b1;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_cpu_rst = 1'b1;
    endtask

    // Returns #1 after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b, input int gap_in, input bit pulse);
        bit ok;
        int gap;
        gap = (pulse && gap_in == 0) ? 1 : gap_in;
        for (int g = 0; g < gap; g++) begin
            bus_if.byte_valid = 1'b0;
            bus_if.byte_data  = 8'($urandom);
            bus_if.start      = pulse && (g == 0);
            @(posedge clk); #1;
        end
        bus_if.start      = 1'b0;
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus_if.byte_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus_if.byte_valid = 1'b0;
        bus_if.byte_data  = 8'($urandom);
        check("byte_accepted", {31'd0, ok}, 32'd1);
    endtask

    // stop_after > 0 sends only that many bytes of the stream.
    task automatic run_load(input byte_q_t s, input int max_gap, input int pulse_idx, input int stop_after);
        int n, last, nb, k;
        logic [31:0] acc;
        logic [7:0]  x;
        n    = int'(s[0]);
        last = (n > 64) ? 0 : 4 * n + 1;
        nb   = (stop_after > 0) ? stop_after : last + 1;
        acc  = 32'd0;
        x    = 8'd0;
        do_start();
        for (int j = 0; j < nb; j++) begin
            send_byte(s[j], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, j == pulse_idx);
            if (n <= 64 && j >= 1 && j <= 4 * n) begin
                k   = j - 1;
                acc = acc | (32'(s[j]) << (8 * (k % 4)));
                x   = x ^ s[j];
                if (k % 4 == 3) begin
                    m_we_due  = 1'b1;
                    m_wr_addr = 6'(k / 4);
                    m_wr_data = acc;
                    acc       = 32'd0;
                end
            end
            if (j == last) begin
                m_busy = 1'b0;
                if (n > 64)        m_err  = 1'b1;
                else if (s[j] == x) m_done = 1'b1;
                else               m_err  = 1'b1;
            end
        end
        if (stop_after == 0) begin
            @(posedge clk); #1;
            m_cpu_rst = !m_done;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t s;
        int      w0;
        logic [7:0] x;

        reset             = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.byte_valid = 1'b0;
        bus_if.byte_data  = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", {31'd0, bus_if.byte_ready}, 32'd0);
        check("rst_imem_we",    {31'd0, bus_if.imem_we},    32'd0);
        check("rst_imem_addr",  {26'd0, bus_if.imem_addr},  32'd0);
        check("rst_imem_wdata", bus_if.imem_wdata,          32'd0);
        check("rst_cpu_reset",  {31'd0, bus_if.cpu_reset},  32'd1);
        check("rst_busy",       {31'd0, bus_if.busy},       32'd0);
        check("rst_done",       {31'd0, bus_if.done},       32'd0);
        check("rst_error",      {31'd0, bus_if.error},      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // single word, good checksum
        w0 = wr_seen;
        s = {8'h01, 8'h05, 8'h00, 8'h02, 8'h20, 8'h27};
        run_load(s, 0, -1, 0);
        check("t1_writes",   32'(wr_seen - w0),           32'd1);
        check("t1_addr",     {26'd0, last_wr_addr},       32'd0);
        check("t1_wdata",    last_wr_data,                32'h2002_0005);
        check("t1_done",     {31'd0, bus_if.done},        32'd1);
        check("t1_error",    {31'd0, bus_if.error},       32'd0);
        check("t1_cpu_rst",  {31'd0, bus_if.cpu_reset},   32'd0);

        // bad checksum
        w0 = wr_seen;
        s = {8'h01, 8'h05, 8'h00, 8'h02, 8'h20, 8'h26};
        run_load(s, 0, -1, 0);
        check("t2_writes",   32'(wr_seen - w0),           32'd1);
        check("t2_wdata",    last_wr_data,                32'h2002_0005);
        check("t2_error",    {31'd0, bus_if.error},       32'd1);
        check("t2_done",     {31'd0, bus_if.done},        32'd0);
        check("t2_cpu_rst",  {31'd0, bus_if.cpu_reset},   32'd1);

        // header one past the memory depth
        w0 = wr_seen;
        s = {8'h41};
        run_load(s, 0, -1, 0);
        check("t3_writes",   32'(wr_seen - w0),           32'd0);
        check("t3_error",    {31'd0, bus_if.error},       32'd1);
        check("t3_busy",     {31'd0, bus_if.busy},        32'd0);

        // full-depth load
        w0 = wr_seen;
        s = {8'h40};
        x = 8'd0;
        for (int i = 0; i < 256; i++) begin
            s.push_back(8'($urandom));
            x = x ^ s[i + 1];
        end
        s.push_back(x);
        run_load(s, 0, -1, 0);
        check("t4_writes",   32'(wr_seen - w0),           32'd64);
        check("t4_last_addr", {26'd0, last_wr_addr},      32'd63);
        check("t4_done",     {31'd0, bus_if.done},        32'd1);

        // empty load
        w0 = wr_seen;
        s = {8'h00, 8'h00};
        run_load(s, 0, -1, 0);
        check("t5_writes",   32'(wr_seen - w0),           32'd0);
        check("t5_done",     {31'd0, bus_if.done},        32'd1);

        // three words with random stalls and a start pulse mid-DATA
        w0 = wr_seen;
        s = {8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hFF, 8'h00,
             8'h01, 8'h80, 8'h7E, 8'hC3};
        x = 8'd0;
        for (int i = 1; i <= 12; i++) x = x ^ s[i];
        s.push_back(x);
        run_load(s, 3, 6, 0);
        check("t6_writes",   32'(wr_seen - w0),           32'd3);
        check("t6_last_addr", {26'd0, last_wr_addr},      32'd2);
        check("t6_last_data", last_wr_data,               32'hC37E_8001);
        check("t6_done",     {31'd0, bus_if.done},        32'd1);

        // reset after the 2nd byte of word 1
        w0 = wr_seen;
        s = {8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        run_load(s, 0, -1, 7);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("ab_byte_ready", {31'd0, bus_if.byte_ready}, 32'd0);
        check("ab_imem_we",    {31'd0, bus_if.imem_we},    32'd0);
        check("ab_imem_addr",  {26'd0, bus_if.imem_addr},  32'd0);
        check("ab_imem_wdata", bus_if.imem_wdata,          32'd0);
        check("ab_cpu_reset",  {31'd0, bus_if.cpu_reset},  32'd1);
        check("ab_busy",       {31'd0, bus_if.busy},       32'd0);
        check("ab_done",       {31'd0, bus_if.done},       32'd0);
        check("ab_error",      {31'd0, bus_if.error},      32'd0);
        check("ab_writes",     32'(wr_seen - w0),          32'd1);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // full reload after the abort
        w0 = wr_seen;
        x = 8'd0;
        for (int i = 1; i <= 8; i++) x = x ^ s[i];
        s[9] = x;
        run_load(s, 0, -1, 0);
        check("t7_writes",   32'(wr_seen - w0),           32'd2);
        check("t7_last_addr", {26'd0, last_wr_addr},      32'd1);
        check("t7_last_data", last_wr_data,               32'h7856_3412);
        check("t7_done",     {31'd0, bus_if.done},        32'd1);
        check("t7_cpu_rst",  {31'd0, bus_if.cpu_reset},   32'd0);

        // restart from DONE raises cpu_reset on the same edge
        do_start();
        check("rs_cpu_rst",  {31'd0, bus_if.cpu_reset},   32'd1);
        check("rs_busy",     {31'd0, bus_if.busy},        32'd1);
        check("rs_done",     {31'd0, bus_if.done},        32'd0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        m_busy = 1'b0;
        m_done = 1'b1;
        @(posedge clk); #1;
        m_cpu_rst = 1'b0;
        check("rs_final_done", {31'd0, bus_if.done},      32'd1);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
